demux6_bram_writer: RTL and testbench
=====================================

// Module: demux6_bram_writer
// PURPOSE
//  Write-side counterpart of the BRAM read path: accepts a tagged sample stream and
//  demultiplexes it into six per-channel regions of one capture BRAM. Sits between the
//  ADC/sample front end and the BRAM write port; the read path selects channels back out.
//  Per-channel write pointers; a capture ends when every enabled channel region is full.
// PARAMETERS
//  WIDTH       8   sample width in bits (bram_din width)
//  DEPTH_LOG2  10  log2 samples per channel region; region size DEPTH = 2**DEPTH_LOG2
// PORTS
//  clk        in   1               system clock, all logic on rising edge
//  rst_n      in   1               asynchronous active-low reset
//  start      in   1               pulse: arm capture (honoured in IDLE and DONE)
//  abort      in   1               pulse: cancel capture, return to IDLE
//  ch_en      in   6               channel enable mask, sampled on accepted start
//  s_data     in   WIDTH           sample data
//  s_chan     in   3               channel tag 0..5; 6,7 invalid
//  s_valid    in   1               sample valid
//  s_ready    out  1               sample ready (beat accepted when s_valid & s_ready)
//  bram_we    out  1               BRAM write enable
//  bram_addr  out  3+DEPTH_LOG2    {chan[2:0], ptr[DEPTH_LOG2-1:0]}
//  bram_din   out  WIDTH           BRAM write data
//  busy       out  1               high in CAPTURE
//  done       out  1               high in DONE
//  full_mask  out  6               per-channel region full flags
//  drop_cnt   out  16              dropped-beat counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; s_ready, bram_we, busy, done = 0; bram_addr, bram_din = 0;
//   full_mask = 0; all pointers = 0; drop_cnt = 0.
//  FSM IDLE -> CAPTURE on start (ch_en!=0); IDLE/DONE -> DONE on start with ch_en==0.
//   CAPTURE -> DONE the cycle after the last enabled region fills.
//   DONE -> CAPTURE on start (re-arm). Any state -> IDLE on abort; abort beats start.
//  On accepted start: latch ch_en, clear pointers, full_mask and drop_cnt.
//  s_ready = 1 only in CAPTURE (registered state; not a function of s_valid).
//  Accepted beat with chan<6, en_latched[chan]=1, full_mask[chan]=0: next cycle
//   bram_we=1, bram_addr={chan,ptr[chan]}, bram_din=s_data; ptr[chan]++ (mod DEPTH).
//   Write latency exactly 1 cycle; bram_we is a one-cycle pulse per beat; back-to-back
//   beats give back-to-back writes (1 beat/cycle throughput).
//  Region fill: write at ptr=DEPTH-1 sets full_mask[chan] in the same cycle as that
//   write's bram_we; ptr wraps to 0 but further beats to that channel are dropped.
//  Dropped beat: chan 6/7, disabled channel, or full channel; no write issued.
//  start in CAPTURE ignored. abort mid-capture: no write for a beat accepted in the same
//   cycle; a write already registered still completes; full_mask holds until next start.
//  bram_addr/bram_din hold last value when bram_we=0.
// CONFIGURATION
//  DEMUX_DROP_CNT_EN defined: drop_cnt counts dropped beats in CAPTURE, saturates at
//   16'hFFFF, cleared on reset and accepted start.
//  Undefined: drop_cnt tied to 16'h0000; no counter logic synthesised.
// TESTING
//  Reset mid-stream (rst_n low 3 cycles during CAPTURE) -> all outputs at reset values,
//   state IDLE, next start behaves as fresh capture.
//  DEPTH_LOG2=2, ch_en=6'b000001, start, 4 beats chan0 data 0x11..0x14 -> writes addr
//   0..3 one cycle after each beat, full_mask=000001, done=1 one cycle after 4th write.
//  ch_en=6'b100010, interleave chan1/chan5 beats 0xA0.. -> addrs {1,0..3},{5,0..3};
//   done only after both full; beats to chan0 produce no bram_we.
//  With DEMUX_DROP_CNT_EN: 3 beats chan=7, 2 beats to full chan1 -> drop_cnt=5, no writes;
//   without macro -> drop_cnt=0.
//  start with ch_en=0 -> done=1 next cycle, s_ready never asserted.
//  abort and start same cycle in DONE -> IDLE, busy=0, done=0, s_ready=0.

Source files
------------

// File: rtl/demux6_bram_writer.sv
`default_nettype none
// ============================================================================
// Module      : demux6_bram_writer
// Description : Demultiplexes a tagged sample stream into six per-channel
//               regions of one capture BRAM. Each channel owns a region of
//               2**DEPTH_LOG2 samples addressed as {chan, ptr}. A capture ends
//               once every enabled region is full.
// Ports       : clk, rst_n (async active-low)
//               start/abort/ch_en      capture control
//               s_data/s_chan/s_valid  tagged sample input; s_ready back
//               bram_we/addr/din       BRAM write port (1-cycle latency)
//               busy/done/full_mask    status
//               drop_cnt               dropped-beat counter
// Options     : `define DEMUX_DROP_CNT_EN to build the saturating drop
//               counter; otherwise drop_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module demux6_bram_writer #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [5:0]            ch_en,
  input  logic [WIDTH-1:0]      s_data,
  input  logic [2:0]            s_chan,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  bram_we,
  output logic [DEPTH_LOG2+2:0] bram_addr,
  output logic [WIDTH-1:0]      bram_din,
  output logic                  busy,
  output logic                  done,
  output logic [5:0]            full_mask,
  output logic [15:0]           drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  start_acc;
  logic [5:0]            en_lat;
  logic [DEPTH_LOG2-1:0] ptr [6];
  logic [DEPTH_LOG2-1:0] cur_ptr;
  logic [7:0]            en8, full8;
  logic                  beat, wr_ok, do_write;

  // Status decodes straight from the state register.
  assign s_ready = (state == ST_CAPTURE);
  assign busy    = (state == ST_CAPTURE);
  assign done    = (state == ST_DONE);

  // Widened copies so the 3-bit tag can index them without range issues;
  // tags 6 and 7 land on the zero padding and are rejected.
  assign en8   = {2'b00, en_lat};
  assign full8 = {2'b00, full_mask};

  assign beat     = s_valid & s_ready;
  assign wr_ok    = beat & (s_chan < 3'd6) & en8[s_chan] & ~full8[s_chan];
  // abort cancels a beat accepted in the same cycle
  assign do_write = wr_ok & ~abort;

  always_comb begin
    cur_ptr = '0;
    for (int i = 0; i < 6; i++) begin
      if (s_chan == 3'(i)) cur_ptr = ptr[i];
    end
  end

  // Next-state logic; abort has priority over everything, including start.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            start_acc = 1'b1;
            state_nxt = (ch_en != 6'd0) ? ST_CAPTURE : ST_DONE;
          end
        end
        ST_CAPTURE: begin
          // full_mask is registered, so this fires the cycle after the
          // final write's full flag appears.
          if ((full_mask & en_lat) == en_lat) state_nxt = ST_DONE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      en_lat    <= 6'd0;
      full_mask <= 6'd0;
      for (int i = 0; i < 6; i++) ptr[i] <= '0;
    end else begin
      bram_we <= do_write;
      if (do_write) begin
        bram_addr <= {s_chan, cur_ptr};
        bram_din  <= s_data;
      end
      if (start_acc) begin
        en_lat    <= ch_en;
        full_mask <= 6'd0;
        for (int i = 0; i < 6; i++) ptr[i] <= '0;
      end else if (do_write) begin
        for (int i = 0; i < 6; i++) begin
          if (s_chan == 3'(i)) begin
            // Pointer wraps to zero; the full flag then blocks the channel.
            ptr[i] <= ptr[i] + 1'b1;
            if (ptr[i] == {DEPTH_LOG2{1'b1}}) full_mask[i] <= 1'b1;
          end
        end
      end
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_q;

  // Beats only arrive in CAPTURE, so any accepted beat that is not a legal
  // write (bad tag, disabled or full channel) is a drop.
  assign drop = beat & ~wr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 16'h0000;
    end else if (start_acc) begin
      drop_q <= 16'h0000;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'h0001;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux6_bram_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux6_bram_writer
// Description : Table-driven self-checking bench for demux6_bram_writer with
//               DEPTH_LOG2=2 (4-sample regions), plus a hand-written
//               mid-stream reset sequence. Drop-count expectations follow
//               DEMUX_DROP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux6_bram_writer;

  localparam int WIDTH      = 8;
  localparam int DEPTH_LOG2 = 2;
`ifdef DEMUX_DROP_CNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, s_valid;
  logic [5:0]  ch_en;
  logic [7:0]  s_data;
  logic [2:0]  s_chan;
  logic        s_ready, bram_we, busy, done;
  logic [4:0]  bram_addr;
  logic [7:0]  bram_din;
  logic [5:0]  full_mask;
  logic [15:0] drop_cnt;

  typedef struct packed {
    logic        rdy;
    logic        we;
    logic [4:0]  addr;
    logic [7:0]  din;
    logic        busy;
    logic        done;
    logic [5:0]  full;
    logic [15:0] drop;
  } out_t;

  typedef struct {
    logic       start;
    logic       abort;
    logic [5:0] ch_en;
    logic       valid;
    logic [2:0] chan;
    logic [7:0] data;
    out_t       exp;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  demux6_bram_writer #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_en(ch_en),
    .s_data(s_data), .s_chan(s_chan), .s_valid(s_valid), .s_ready(s_ready),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .busy(busy), .done(done), .full_mask(full_mask), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic out_t mk_out(input logic rdy, input logic we,
                                  input logic [4:0] a, input logic [7:0] d,
                                  input logic bz, input logic dn,
                                  input logic [5:0] fm, input int nd);
    out_t o;
    o.rdy  = rdy;  o.we   = we;  o.addr = a;  o.din = d;
    o.busy = bz;   o.done = dn;  o.full = fm;
    o.drop = DC_EN ? 16'(nd) : 16'h0000;
    return o;
  endfunction

  function automatic vec_t v(input logic st, input logic ab, input logic [5:0] ce,
                             input logic vl, input logic [2:0] ch, input logic [7:0] d,
                             input out_t e);
    vec_t r;
    r.start = st; r.abort = ab; r.ch_en = ce;
    r.valid = vl; r.chan  = ch; r.data  = d; r.exp = e;
    return r;
  endfunction

  task automatic check(input string name, input out_t e);
    out_t g;
    g = '{rdy: s_ready, we: bram_we, addr: bram_addr, din: bram_din,
          busy: busy, done: done, full: full_mask, drop: drop_cnt};
    n_vec++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b we=%b addr=%h din=%h busy=%b done=%b full=%b drop=%h | exp rdy=%b we=%b addr=%h din=%h busy=%b done=%b full=%b drop=%h",
               name, g.rdy, g.we, g.addr, g.din, g.busy, g.done, g.full, g.drop,
               e.rdy, e.we, e.addr, e.din, e.busy, e.done, e.full, e.drop);
    end
  endtask

  task automatic drive(input logic st, input logic ab, input logic [5:0] ce,
                       input logic vl, input logic [2:0] ch, input logic [7:0] d);
    start = st; abort = ab; ch_en = ce; s_valid = vl; s_chan = ch; s_data = d;
  endtask

  vec_t tbl[$];

  initial begin
    // ---- vector table: inputs for one cycle, outputs after its clock edge
    // A: single channel 0, fill 4 samples, DONE, then abort holds full_mask
    tbl.push_back(v(1,0,6'h01,0,0,8'h00, mk_out(1,0,5'h00,8'h00,1,0,6'h00,0)));
    tbl.push_back(v(0,0,6'h00,1,0,8'h11, mk_out(1,1,5'h00,8'h11,1,0,6'h00,0)));
    tbl.push_back(v(0,0,6'h00,1,0,8'h12, mk_out(1,1,5'h01,8'h12,1,0,6'h00,0)));
    tbl.push_back(v(0,0,6'h00,1,0,8'h13, mk_out(1,1,5'h02,8'h13,1,0,6'h00,0)));
    tbl.push_back(v(0,0,6'h00,1,0,8'h14, mk_out(1,1,5'h03,8'h14,1,0,6'h01,0)));
    tbl.push_back(v(0,0,6'h00,0,0,8'h00, mk_out(0,0,5'h03,8'h14,0,1,6'h01,0)));
    tbl.push_back(v(0,1,6'h00,0,0,8'h00, mk_out(0,0,5'h03,8'h14,0,0,6'h01,0)));
    // B: channels 1 and 5 interleaved, drops to chan0 / full chan1 / tags 6,7
    tbl.push_back(v(1,0,6'h22,0,0,8'h00, mk_out(1,0,5'h03,8'h14,1,0,6'h00,0)));
    tbl.push_back(v(0,0,6'h00,1,1,8'hA0, mk_out(1,1,5'h04,8'hA0,1,0,6'h00,0)));
    tbl.push_back(v(0,0,6'h00,1,5,8'hA1, mk_out(1,1,5'h14,8'hA1,1,0,6'h00,0)));
    tbl.push_back(v(0,0,6'h00,1,0,8'hA2, mk_out(1,0,5'h14,8'hA1,1,0,6'h00,1)));
    tbl.push_back(v(0,0,6'h00,1,1,8'hA3, mk_out(1,1,5'h05,8'hA3,1,0,6'h00,1)));
    tbl.push_back(v(0,0,6'h00,1,5,8'hA4, mk_out(1,1,5'h15,8'hA4,1,0,6'h00,1)));
    tbl.push_back(v(0,0,6'h00,1,1,8'hA5, mk_out(1,1,5'h06,8'hA5,1,0,6'h00,1)));
    tbl.push_back(v(0,0,6'h00,1,1,8'hA6, mk_out(1,1,5'h07,8'hA6,1,0,6'h02,1)));
    tbl.push_back(v(0,0,6'h00,1,1,8'hA7, mk_out(1,0,5'h07,8'hA6,1,0,6'h02,2)));
    tbl.push_back(v(0,0,6'h00,1,7,8'hA8, mk_out(1,0,5'h07,8'hA6,1,0,6'h02,3)));
    tbl.push_back(v(0,0,6'h00,1,5,8'hA9, mk_out(1,1,5'h16,8'hA9,1,0,6'h02,3)));
    tbl.push_back(v(0,0,6'h00,1,5,8'hAA, mk_out(1,1,5'h17,8'hAA,1,0,6'h22,3)));
    tbl.push_back(v(0,0,6'h00,1,6,8'hAB, mk_out(0,0,5'h17,8'hAA,0,1,6'h22,4)));
    tbl.push_back(v(0,0,6'h00,1,1,8'hAC, mk_out(0,0,5'h17,8'hAA,0,1,6'h22,4)));
    // C: empty mask start, abort-beats-start in DONE, empty start from IDLE
    tbl.push_back(v(1,0,6'h00,0,0,8'h00, mk_out(0,0,5'h17,8'hAA,0,1,6'h00,0)));
    tbl.push_back(v(1,1,6'h01,0,0,8'h00, mk_out(0,0,5'h17,8'hAA,0,0,6'h00,0)));
    tbl.push_back(v(0,0,6'h00,1,0,8'h55, mk_out(0,0,5'h17,8'hAA,0,0,6'h00,0)));
    tbl.push_back(v(1,0,6'h00,0,0,8'h00, mk_out(0,0,5'h17,8'hAA,0,1,6'h00,0)));
    // D: ch0+ch1, fill ch1 (start in CAPTURE ignored), then 3 x tag7, 2 x full ch1
    tbl.push_back(v(1,0,6'h03,0,0,8'h00, mk_out(1,0,5'h17,8'hAA,1,0,6'h00,0)));
    tbl.push_back(v(0,0,6'h00,1,1,8'hB0, mk_out(1,1,5'h04,8'hB0,1,0,6'h00,0)));
    tbl.push_back(v(1,0,6'h00,1,1,8'hB1, mk_out(1,1,5'h05,8'hB1,1,0,6'h00,0)));
    tbl.push_back(v(0,0,6'h00,1,1,8'hB2, mk_out(1,1,5'h06,8'hB2,1,0,6'h00,0)));
    tbl.push_back(v(0,0,6'h00,1,1,8'hB3, mk_out(1,1,5'h07,8'hB3,1,0,6'h02,0)));
    tbl.push_back(v(0,0,6'h00,1,7,8'hB4, mk_out(1,0,5'h07,8'hB3,1,0,6'h02,1)));
    tbl.push_back(v(0,0,6'h00,1,7,8'hB5, mk_out(1,0,5'h07,8'hB3,1,0,6'h02,2)));
    tbl.push_back(v(0,0,6'h00,1,7,8'hB6, mk_out(1,0,5'h07,8'hB3,1,0,6'h02,3)));
    tbl.push_back(v(0,0,6'h00,1,1,8'hB7, mk_out(1,0,5'h07,8'hB3,1,0,6'h02,4)));
    tbl.push_back(v(0,0,6'h00,1,1,8'hB8, mk_out(1,0,5'h07,8'hB3,1,0,6'h02,5)));
    // E: write on ch0, then abort with a beat in the same cycle (no write)
    tbl.push_back(v(0,0,6'h00,1,0,8'hC0, mk_out(1,1,5'h00,8'hC0,1,0,6'h02,5)));
    tbl.push_back(v(0,1,6'h00,1,0,8'hC1, mk_out(0,0,5'h00,8'hC0,0,0,6'h02,5)));

    // ---- reset
    rst_n = 1'b0;
    drive(0,0,6'h00,0,0,8'h00);
    repeat (2) @(negedge clk);
    check("reset", mk_out(0,0,5'h00,8'h00,0,0,6'h00,0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", mk_out(0,0,5'h00,8'h00,0,0,6'h00,0));

    // ---- table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].start, tbl[i].abort, tbl[i].ch_en,
            tbl[i].valid, tbl[i].chan, tbl[i].data);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // ---- hand sequence: reset asserted mid-capture for 3 cycles
    drive(1,0,6'h01,0,0,8'h00);
    @(negedge clk);
    drive(0,0,6'h00,1,0,8'hE0);
    @(negedge clk);
    check("mid_write", mk_out(1,1,5'h00,8'hE0,1,0,6'h00,0));
    drive(0,0,6'h00,1,0,8'hE1);
    rst_n = 1'b0;
    #1;
    check("async_reset", mk_out(0,0,5'h00,8'h00,0,0,6'h00,0));
    repeat (3) @(negedge clk);
    check("reset_held", mk_out(0,0,5'h00,8'h00,0,0,6'h00,0));
    rst_n = 1'b1;
    drive(0,0,6'h00,0,0,8'h00);
    @(negedge clk);
    check("reset_idle", mk_out(0,0,5'h00,8'h00,0,0,6'h00,0));
    drive(1,0,6'h01,0,0,8'h00);
    @(negedge clk);
    check("fresh_start", mk_out(1,0,5'h00,8'h00,1,0,6'h00,0));
    drive(0,0,6'h00,1,0,8'hD0);
    @(negedge clk);
    check("fresh_write0", mk_out(1,1,5'h00,8'hD0,1,0,6'h00,0));
    drive(0,0,6'h00,1,0,8'hD1);
    @(negedge clk);
    check("fresh_write1", mk_out(1,1,5'h01,8'hD1,1,0,6'h00,0));
    drive(0,0,6'h00,0,0,8'h00);
    @(negedge clk);
    check("fresh_hold", mk_out(1,0,5'h01,8'hD1,1,0,6'h00,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
